// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared types and helpers for the fetch/data memory port arbiter
package memory_port_arbiter_pkg;

  typedef logic [31:0] vec32_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arbiter_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_FETCH,
    OWNER_DATA
  } arbiter_owner_t;

  // Width of a counter that must hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_priority.sv
// rtl/memory_port_arbiter_priority.sv - grant decision for the IDLE arbitration slot
// ARBITER_ANTI_STARVE_EN adds a counter that forces a fetch grant after STARVE_LIMIT data wins.
module memory_port_arbiter_priority
  import memory_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_arb_en,
  input  logic           i_fetch_req,
  input  logic           i_data_req,
  output arbiter_owner_t o_winner
);

`ifdef ARBITER_ANTI_STARVE_EN
  localparam int SW = cnt_width(STARVE_LIMIT);

  logic [SW-1:0] r_starve_count;
  logic          w_force_fetch;

  assign w_force_fetch = (r_starve_count == SW'(STARVE_LIMIT));

  always_comb begin
    o_winner = OWNER_NONE;
    if (i_data_req && !(w_force_fetch && i_fetch_req)) o_winner = OWNER_DATA;
    else if (i_fetch_req)                              o_winner = OWNER_FETCH;
  end

  // Only arbitrations that actually grant something move the counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve_count <= '0;
    end else if (i_arb_en && o_winner != OWNER_NONE) begin
      if (o_winner == OWNER_FETCH || !i_fetch_req)
        r_starve_count <= '0;
      else if (!w_force_fetch)
        r_starve_count <= r_starve_count + 1'b1;
    end
  end
`else
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, i_clock, i_reset, i_arb_en};

  always_comb begin
    o_winner = OWNER_NONE;
    if (i_data_req)       o_winner = OWNER_DATA;
    else if (i_fetch_req) o_winner = OWNER_FETCH;
  end
`endif

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one single-port memory between fetch and load/store requesters
// Optional fetch anti-starvation is enabled by defining ARBITER_ANTI_STARVE_EN.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_address,
  output logic        o_fetch_done,
  output logic [31:0] o_fetch_read_data,
  output logic        o_fetch_stall,
  input  logic        i_data_req,
  input  logic        i_data_write,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_write_data,
  output logic        o_data_done,
  output logic [31:0] o_data_read_data,
  output logic        o_data_stall,
  output logic        o_access_error,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_read_data
);

  localparam int TW = cnt_width(ACK_TIMEOUT);

  arbiter_state_t r_state;
  arbiter_owner_t r_owner;
  logic [TW-1:0]  r_timer;
  logic           r_write;
  vec32_t         r_addr;
  vec32_t         r_wdata;
  logic           r_fetch_done;
  logic           r_data_done;
  logic           r_access_error;
  vec32_t         r_fetch_rdata;
  vec32_t         r_data_rdata;

  arbiter_owner_t w_winner;
  logic           w_in_access;
  logic           w_timeout;
  logic           w_win_data;

  memory_port_arbiter_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_arb_en    (r_state == IDLE),
    .i_fetch_req (i_fetch_req),
    .i_data_req  (i_data_req),
    .o_winner    (w_winner)
  );

  assign w_in_access = (r_state == ACCESS);
  assign w_win_data  = (w_winner == OWNER_DATA);
  assign w_timeout   = (ACK_TIMEOUT != 0) && (r_timer == TW'(ACK_TIMEOUT));

  // Request attributes are latched at grant so a dropped request cannot disturb the access.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_owner        <= OWNER_NONE;
      r_timer        <= '0;
      r_write        <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_fetch_done   <= 1'b0;
      r_data_done    <= 1'b0;
      r_access_error <= 1'b0;
      r_fetch_rdata  <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_fetch_done   <= 1'b0;
      r_data_done    <= 1'b0;
      r_access_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_winner != OWNER_NONE) begin
            r_state <= ACCESS;
            r_owner <= w_winner;
            r_timer <= '0;
            r_write <= w_win_data && i_data_write;
            r_addr  <= w_win_data ? i_data_address : i_fetch_address;
            r_wdata <= w_win_data ? i_data_write_data : '0;
          end
        end
        ACCESS: begin
          if (i_mem_ack || w_timeout) begin
            r_state        <= DONE;
            r_fetch_done   <= (r_owner == OWNER_FETCH);
            r_data_done    <= (r_owner == OWNER_DATA);
            r_access_error <= !i_mem_ack;
            if (i_mem_ack && !r_write) begin
              if (r_owner == OWNER_FETCH) r_fetch_rdata <= i_mem_read_data;
              else                        r_data_rdata  <= i_mem_read_data;
            end
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_owner <= OWNER_NONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_req         = w_in_access;
  assign o_mem_write       = w_in_access && r_write;
  assign o_mem_address     = w_in_access ? r_addr : '0;
  assign o_mem_write_data  = w_in_access ? r_wdata : '0;

  assign o_fetch_done      = r_fetch_done;
  assign o_data_done       = r_data_done;
  assign o_access_error    = r_access_error;
  assign o_fetch_read_data = r_fetch_rdata;
  assign o_data_read_data  = r_data_rdata;
  assign o_fetch_stall     = i_fetch_req && !r_fetch_done;
  assign o_data_stall      = i_data_req && !r_data_done;

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-port backing memory between the fetch stage (read-only instruction requests) and the memory stage (load/store requests). It arbitrates between them, sequences each access through a request/acknowledge handshake with the memory, returns read data and a completion pulse to the winning stage, and drives per-stage stall signals that feed the pipeline stall logic. Sits between the fetch/memory pipeline stages and a unified instruction/data memory.

## Interface
- STARVE_LIMIT, 4: consecutive data grants with a pending fetch before fetch is forced to win (≥1).
- ACK_TIMEOUT, 255: maximum ACCESS cycles to wait for `memAck`; 0 disables the timeout.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetchReq  in  1  fetch request; held until `fetchDone`.
- fetchAddress  in  32  word address; stable while `fetchReq` is high.
- fetchDone  out  1  one-cycle completion pulse.
- fetchReadData  out  32  instruction word; valid when `fetchDone` is high.
- fetchStall  out  1  `fetchReq && !fetchDone` (combinational).
- dataReq  in  1  data request; held until `dataDone`.
- dataWrite  in  1  1 = store, 0 = load; stable while `dataReq` is high.
- dataAddress  in  32  word address.
- dataWriteData  in  32  store data.
- dataDone  out  1  one-cycle completion pulse.
- dataReadData  out  32  load data; valid when `dataDone` is high.
- dataStall  out  1  `dataReq && !dataDone` (combinational).
- accessError  out  1  high together with the `*Done` pulse of an access that timed out.
- memReq  out  1  memory request; high throughout ACCESS.
- memWrite, memAddress, memWriteData  out  1/32/32  muxed from the owner; zero outside ACCESS.
- memAck  in  1  one-cycle acknowledge; may arrive in the first ACCESS cycle.
- memReadData  in  32  valid in the `memAck` cycle.

## Operation
- States:
  - IDLE → ACCESS when any request is pending. The winner is latched into the `owner` register.
  - ACCESS → DONE on `memAck`, or on timeout.
  - DONE → IDLE unconditionally.
- Arbitration happens in IDLE only. Data wins over fetch, unless starvation override applies (see Configuration).
- On the `memAck` edge:
  - Load or fetch: `memReadData` is captured into the owner's read-data register.
  - Store: the read-data register is unchanged.
- DONE: the owner's `*Done` output is high for exactly one cycle.
- Timeout: when ACCESS has lasted ACK_TIMEOUT cycles without `memAck`, the FSM moves to DONE with `accessError` = 1. Read data is left unchanged. A late `memAck` arriving in DONE or IDLE is ignored.
- Requester rules:
  - A requester drops its request in the cycle after its `*Done` pulse, or issues a new one.
  - A request dropped mid-ACCESS does not cancel the access; the access completes and `*Done` still pulses.
- Reset, including mid-ACCESS: state = IDLE, `owner` cleared, counters = 0. All outputs read 0: both `*Done`, both read-data registers, `accessError`, `memReq`, and the `mem*` buses. The in-flight access is abandoned.

## Timing
- Request first seen high at edge N:
  - ACCESS (`memReq` = 1) during cycle N+1.
  - If `memAck` arrives in cycle N+1+k, `*Done` is high in cycle N+2+k.
- Minimum latency: 2 cycles (k = 0). Minimum issue interval: 3 cycles per access.
- Simultaneous `fetchReq` and `dataReq` in IDLE: exactly one is granted. The loser stays stalled and is re-arbitrated in the next IDLE.
- Timeout counter:
  - Width is `$clog2(ACK_TIMEOUT+1)`.
  - Cleared on ACCESS entry; saturates, never wraps.
- The `*Stall` outputs are combinational from the requests and the registered `*Done` outputs.

## Configuration
- `ARBITER_ANTI_STARVE_EN` defined:
  - Counter `starveCount` increments on each data grant made while `fetchReq` is high.
  - It clears on a fetch grant, and on any IDLE arbitration where `fetchReq` is low.
  - When `starveCount == STARVE_LIMIT`, the next arbitration grants fetch even if `dataReq` is high.
- Undefined: strict data-over-fetch priority, and no counter logic is synthesized.

## Structure
- Shared package / `common.vh`:
  - `Vec32` (already defined there).
  - New enum `ArbiterState` {IDLE, ACCESS, DONE}.
  - New enum `ArbiterOwner` {OWNER_NONE, OWNER_FETCH, OWNER_DATA}.
- One sub-module: `MemoryArbiterPriority`. It holds the grant decision plus the `ARBITER_ANTI_STARVE_EN` starvation counter, and outputs the winning owner for IDLE.

## Test plan
- Single fetch:
  - Stimulus: `fetchReq` at addr 0x100; memory acks in the first ACCESS cycle with 0x2402000A.
  - Expected: `fetchDone` 2 cycles after the request; `fetchReadData` = 0x2402000A; `fetchStall` high for exactly 2 cycles.
- Simultaneous requests:
  - Stimulus: fetch (0x104) and store (addr 0x40, data 0xDEADBEEF) in the same cycle.
  - Expected: store issues first (`memWrite` = 1, `memWriteData` = 0xDEADBEEF); fetch issues 3 cycles later.
- Starvation, with `ARBITER_ANTI_STARVE_EN` and STARVE_LIMIT = 2:
  - Stimulus: continuous `dataReq` and `fetchReq`.
  - Expected grant order: data, data, fetch, data, data, fetch.
  - Without the macro: fetch is never granted while `dataReq` stays high.
- Timeout:
  - Stimulus: ACK_TIMEOUT = 3; memory never acks a load.
  - Expected: `dataDone` and `accessError` both high 5 cycles after the request; `dataReadData` holds its prior value.
- Reset mid-ACCESS:
  - Stimulus: assert reset during a delayed-ack load.
  - Expected: next cycle `memReq` = 0, all outputs 0; an ack arriving after reset produces no `*Done`.
